// File: rtl/sync_fifo_param.sv
// ============================================================================
//  Module   : sync_fifo_param
//  Purpose  : Parametrised single-clock FIFO with normal or show-ahead reads,
//             run-time almost-full/almost-empty thresholds and synchronous
//             flush. Optional statistics outputs are enabled by defining
//             SYNC_FIFO_PARAM_STAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    SHOW_AHEAD = 0,
    parameter logic [DATA_WIDTH-1:0] DOUT_INIT  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  re,
    input  logic [ADDR_WIDTH:0]   afull_th,
    input  logic [ADDR_WIDTH:0]   aempty_th,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  afull,
    output logic                  aempty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  wr_success,
    output logic [ADDR_WIDTH:0]   usedw
`ifdef SYNC_FIFO_PARAM_STAT_EN
    ,
    output logic [ADDR_WIDTH:0]   peak_usedw,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           udf_cnt
`endif
);

    localparam int                  DEPTH_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  readable;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ovf_ev;
    logic                  udf_ev;
    logic [ADDR_WIDTH:0]   cnt_nxt;

    // Accept/reject decisions and next occupancy; flush overrides everything.
    always_comb begin
        wr_ok   = we && !full_flag && !clr;
        rd_ok   = re && readable && !clr;
        ovf_ev  = we && full_flag && !clr;
        udf_ev  = re && !readable && !clr;
        cnt_nxt = usedw;
        if (clr)
            cnt_nxt = '0;
        else if (wr_ok && !rd_ok)
            cnt_nxt = usedw + CNT_ONE;
        else if (!wr_ok && rd_ok)
            cnt_nxt = usedw - CNT_ONE;
    end

    // Storage array: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= di;
    end

    // Write pointer, occupancy, flags and event pulses, all from cnt_nxt so
    // every flag changes on the same edge as usedw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            usedw      <= '0;
            empty_flag <= 1'b1;
            full_flag  <= 1'b0;
            afull      <= 1'b0;
            aempty     <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            wr_success <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            usedw      <= '0;
            empty_flag <= 1'b1;
            full_flag  <= 1'b0;
            afull      <= 1'b0;
            aempty     <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            wr_success <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            usedw      <= cnt_nxt;
            empty_flag <= (cnt_nxt == '0);
            full_flag  <= (cnt_nxt == DEPTH);
            afull      <= (cnt_nxt >= afull_th);
            aempty     <= (cnt_nxt <= aempty_th);
            overflow   <= ovf_ev;
            underflow  <= udf_ev;
            wr_success <= wr_ok;
        end
    end

    generate
        if (SHOW_AHEAD == 0) begin : g_normal
            logic [DATA_WIDTH-1:0] ram_q;
            logic                  rd_pend;

            assign readable = !empty_flag;

            // Two-stage read: RAM output register on the accepting edge,
            // then dout/valid on the following edge for exactly one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr  <= '0;
                    ram_q   <= DOUT_INIT;
                    rd_pend <= 1'b0;
                    dout    <= DOUT_INIT;
                    valid   <= 1'b0;
                end else if (clr) begin
                    rd_ptr  <= '0;
                    ram_q   <= DOUT_INIT;
                    rd_pend <= 1'b0;
                    dout    <= DOUT_INIT;
                    valid   <= 1'b0;
                end else begin
                    rd_pend <= rd_ok;
                    if (rd_ok) begin
                        ram_q  <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + PTR_ONE;
                    end
                    if (rd_pend)
                        dout <= ram_q;
                    valid <= rd_pend;
                end
            end
        end else begin : g_show_ahead
            logic [ADDR_WIDTH:0] mem_words;
            logic                load;

            assign readable = valid;

            // Words still in RAM (not yet in dout); a load refills dout when
            // it is empty or being popped this cycle.
            always_comb begin
                mem_words = usedw - {{ADDR_WIDTH{1'b0}}, valid};
                load      = (mem_words != '0) && (!valid || rd_ok);
            end

            // dout is the RAM read register itself, so a pop and the next
            // word's load share one edge and no bubble appears.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr <= '0;
                    dout   <= DOUT_INIT;
                    valid  <= 1'b0;
                end else if (clr) begin
                    rd_ptr <= '0;
                    dout   <= DOUT_INIT;
                    valid  <= 1'b0;
                end else if (load) begin
                    dout   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + PTR_ONE;
                    valid  <= 1'b1;
                end else if (rd_ok) begin
                    valid  <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_PARAM_STAT_EN
    // Peak occupancy and saturating reject counters, cleared by reset/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_usedw <= '0;
            ovf_cnt    <= '0;
            udf_cnt    <= '0;
        end else if (clr) begin
            peak_usedw <= '0;
            ovf_cnt    <= '0;
            udf_cnt    <= '0;
        end else begin
            if (cnt_nxt > peak_usedw)
                peak_usedw <= cnt_nxt;
            if (ovf_ev && (ovf_cnt != 16'hFFFF))
                ovf_cnt <= ovf_cnt + 16'd1;
            if (udf_ev && (udf_cnt != 16'hFFFF))
                udf_cnt <= udf_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Purpose  : Directed self-checking bench for sync_fifo_param; one normal
//             mode instance (128 x 512) and one show-ahead instance (8 x 16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         n_clr = 1'b0, n_we = 1'b0, n_re = 1'b0;
    logic [127:0] n_di = '0;
    logic [9:0]   n_afull_th = 10'd500, n_aempty_th = 10'd8;
    logic [127:0] n_dout;
    logic         n_valid, n_empty, n_full, n_afull, n_aempty;
    logic         n_ovf, n_udf, n_wrs;
    logic [9:0]   n_usedw;

    logic         s_clr = 1'b0, s_we = 1'b0, s_re = 1'b0;
    logic [7:0]   s_di = '0;
    logic [4:0]   s_afull_th = 5'd16, s_aempty_th = 5'd0;
    logic [7:0]   s_dout;
    logic         s_valid, s_empty, s_full, s_afull, s_aempty;
    logic         s_ovf, s_udf, s_wrs;
    logic [4:0]   s_usedw;

`ifdef SYNC_FIFO_PARAM_STAT_EN
    logic [9:0]   n_peak;
    logic [15:0]  n_ovf_cnt, n_udf_cnt;
    logic [4:0]   s_peak;
    logic [15:0]  s_ovf_cnt, s_udf_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(128), .ADDR_WIDTH(9), .SHOW_AHEAD(0), .DOUT_INIT('0)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .clr(n_clr), .we(n_we), .di(n_di), .re(n_re),
        .afull_th(n_afull_th), .aempty_th(n_aempty_th),
        .dout(n_dout), .valid(n_valid), .empty_flag(n_empty), .full_flag(n_full),
        .afull(n_afull), .aempty(n_aempty), .overflow(n_ovf), .underflow(n_udf),
        .wr_success(n_wrs), .usedw(n_usedw)
`ifdef SYNC_FIFO_PARAM_STAT_EN
        , .peak_usedw(n_peak), .ovf_cnt(n_ovf_cnt), .udf_cnt(n_udf_cnt)
`endif
    );

    sync_fifo_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SHOW_AHEAD(1), .DOUT_INIT(8'h3C)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .we(s_we), .di(s_di), .re(s_re),
        .afull_th(s_afull_th), .aempty_th(s_aempty_th),
        .dout(s_dout), .valid(s_valid), .empty_flag(s_empty), .full_flag(s_full),
        .afull(s_afull), .aempty(s_aempty), .overflow(s_ovf), .underflow(s_udf),
        .wr_success(s_wrs), .usedw(s_usedw)
`ifdef SYNC_FIFO_PARAM_STAT_EN
        , .peak_usedw(s_peak), .ovf_cnt(s_ovf_cnt), .udf_cnt(s_udf_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset values ----------------
        repeat (3) tick();
        chk("rst_usedw",  n_usedw, 0);
        chk("rst_empty",  n_empty, 1);
        chk("rst_aempty", n_aempty, 1);
        chk("rst_full",   n_full, 0);
        chk("rst_afull",  n_afull, 0);
        chk("rst_valid",  n_valid, 0);
        chk("rst_dout",   n_dout, 0);
        chk("rst_pulses", {n_ovf, n_udf, n_wrs}, 0);
        chk("rst_s_dout", s_dout, 8'h3C);
        chk("rst_s_valid", s_valid, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- show-ahead: first word fall-through ----------------
        s_we = 1'b1; s_di = 8'hA5;
        tick();
        chk("sa_valid_N", s_valid, 0);
        chk("sa_usedw_N", s_usedw, 1);
        s_we = 1'b0;
        tick();
        chk("sa_valid_N1", s_valid, 1);
        chk("sa_dout_N1",  s_dout, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            s_we = 1'b1; s_di = 8'hB0 + 8'(i);
            tick();
        end
        s_we = 1'b0;
        chk("sa_usedw5", s_usedw, 5);
        chk("sa_hold",   s_dout, 8'hA5);
        s_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sa_stream_dout",  s_dout, 8'hB0 + 8'(i));
            chk("sa_stream_valid", s_valid, 1);
            chk("sa_stream_usedw", s_usedw, 4 - i);
        end
        tick();
        chk("sa_last_valid", s_valid, 0);
        chk("sa_last_usedw", s_usedw, 0);
        chk("sa_last_empty", s_empty, 1);
        tick();
        chk("sa_udf", s_udf, 1);
        s_we = 1'b1; s_di = 8'h5A;
        tick();
        chk("sa_wr_rd_empty_udf",   s_udf, 1);
        chk("sa_wr_rd_empty_usedw", s_usedw, 1);
        chk("sa_wr_rd_empty_wrs",   s_wrs, 1);
        s_we = 1'b0; s_re = 1'b0;
        tick();
        chk("sa_5a_valid", s_valid, 1);
        chk("sa_5a_dout",  s_dout, 8'h5A);

        // ---------------- normal mode: fill 512 with thresholds ----------------
        n_we = 1'b1;
        for (int i = 0; i < 512; i++) begin
            n_di = 128'(i);
            tick();
            if (i == 0)   chk("fill_wrs", n_wrs, 1);
            if (i == 0)   chk("fill_empty0", n_empty, 0);
            if (i == 7)   chk("aempty_at8", n_aempty, 1);
            if (i == 8)   chk("aempty_at9", n_aempty, 0);
            if (i == 498) chk("afull_at499", n_afull, 0);
            if (i == 499) chk("afull_at500", n_afull, 1);
            if (i == 510) chk("full_at511", n_full, 0);
        end
        chk("full_usedw", n_usedw, 512);
        chk("full_flag",  n_full, 1);
        n_di = 128'd999;
        tick();
        chk("ovf_513",   n_ovf, 1);
        chk("ovf_wrs",   n_wrs, 0);
        chk("ovf_usedw", n_usedw, 512);
        n_we = 1'b0;

        // ---------------- normal mode: drain 512 ----------------
        n_re = 1'b1;
        for (int k = 0; k < 512; k++) begin
            tick();
            if (k == 0) chk("rd_lat_valid0", n_valid, 0);
            if (k > 0) begin
                chk("rd_dout",  n_dout, 128'(k - 1));
                chk("rd_valid", n_valid, 1);
            end
            if (k == 502) chk("aempty_drain9", n_aempty, 0);
            if (k == 503) chk("aempty_drain8", n_aempty, 1);
        end
        n_re = 1'b0;
        tick();
        chk("rd_last_dout", n_dout, 128'd511);
        chk("rd_empty",     n_empty, 1);
        chk("rd_usedw0",    n_usedw, 0);
        n_re = 1'b1;
        tick();
        chk("udf_513",      n_udf, 1);
        chk("udf_no_valid", n_valid, 0);
        n_re = 1'b0;
        tick();
        chk("udf_clear",    n_udf, 0);
        chk("dout_holds",   n_dout, 128'd511);

        // ---------------- boundary: simultaneous we/re at full and empty ----
        n_we = 1'b1;
        for (int i = 0; i < 512; i++) begin
            n_di = 128'h1000 + 128'(i);
            tick();
        end
        n_di = 128'hDEAD; n_re = 1'b1;
        tick();
        chk("full_wr_rd_usedw", n_usedw, 511);
        chk("full_wr_rd_ovf",   n_ovf, 1);
        chk("full_wr_rd_wrs",   n_wrs, 0);
        n_we = 1'b0;
        for (int j = 0; j < 511; j++) begin
            tick();
            if (j == 0)   chk("full_rd_head", n_dout, 128'h1000);
            if (j == 510) chk("full_rd_tail", n_dout, 128'h11FE);
        end
        n_re = 1'b0;
        tick();
        chk("full_rd_final", n_dout, 128'h11FF);
        chk("full_rd_usedw", n_usedw, 0);
        n_we = 1'b1; n_re = 1'b1; n_di = 128'd7;
        tick();
        chk("empty_wr_rd_usedw", n_usedw, 1);
        chk("empty_wr_rd_udf",   n_udf, 1);
        chk("empty_wr_rd_wrs",   n_wrs, 1);
        n_re = 1'b0;

        // ---------------- flush with concurrent write ----------------
        for (int i = 0; i < 99; i++) begin
            n_di = 128'd100 + 128'(i);
            tick();
        end
        n_we = 1'b0;
        chk("pre_clr_usedw", n_usedw, 100);
        n_re = 1'b1;
        tick();
        n_re = 1'b0; n_clr = 1'b1; n_we = 1'b1;
        tick();
        chk("clr_usedw",  n_usedw, 0);
        chk("clr_empty",  n_empty, 1);
        chk("clr_valid",  n_valid, 0);
        chk("clr_wrs",    n_wrs, 0);
        chk("clr_dout",   n_dout, 0);
        chk("clr_flags",  {n_full, n_afull, n_aempty, n_ovf, n_udf}, 5'b00100);
        n_clr = 1'b0; n_di = 128'h55;
        repeat (3) tick();
        chk("post_clr_usedw", n_usedw, 3);

        // ---------------- asynchronous reset mid-stream ----------------
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_usedw", n_usedw, 0);
        chk("arst_empty", n_empty, 1);
        chk("arst_wrs",   n_wrs, 0);
        chk("arst_s_dout", s_dout, 8'h3C);
        chk("arst_s_usedw", s_usedw, 0);
        n_we = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- fill 300 / drain / rejected reads ----------------
        n_we = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n_di = 128'(i);
            tick();
        end
        n_we = 1'b0;
        chk("st_fill300", n_usedw, 300);
        n_re = 1'b1;
        repeat (290) tick();
        chk("st_drain10", n_usedw, 10);
        repeat (13) tick();
        chk("st_empty", n_usedw, 0);
        chk("st_udf",   n_udf, 1);
        n_re = 1'b0;
        tick();
`ifdef SYNC_FIFO_PARAM_STAT_EN
        chk("st_peak", n_peak, 300);
        chk("st_udf_cnt", n_udf_cnt, 3);
        chk("st_ovf_cnt", n_ovf_cnt, 0);
`endif

        // ---------------- threshold change: afull_th=0 ----------------
        n_afull_th = 10'd0;
        tick();
        chk("afull_th0", n_afull, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
